// File: rtl/puertos_host_if.sv
// rtl/puertos_host_if.sv - CPU I/O port bundle between the host block and the processor board
interface puertos_host_if;
   logic [7:0] d0_e;
   logic [7:0] d1_e;
   logic [7:0] d2_e;
   logic [7:0] d3_e;
   logic [7:0] d0_s;
   logic [7:0] d1_s;
   logic [7:0] d2_s;
   logic [7:0] d3_s;

   modport master (
      output d0_e, d1_e, d2_e, d3_e,
      input  d0_s, d1_s, d2_s, d3_s
   );

   modport slave (
      input  d0_e, d1_e, d2_e, d3_e,
      output d0_s, d1_s, d2_s, d3_s
   );
endinterface

// File: rtl/puertos_host.sv
// rtl/puertos_host.sv - host peer of the CPU I/O ports: TX/RX FIFOs over two toggle-handshake byte channels
// Optional sticky ack timeout is built in when PUERTOS_HOST_ACK_TIMEOUT_EN is defined.
module puertos_host #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           tx_wr,
   input  logic [7:0]     tx_data,
   output logic           tx_full,
   input  logic           rx_rd,
   output logic [7:0]     rx_data,
   output logic           rx_empty,
   output logic           busy,
   output logic           timeout_err,
   puertos_host_if.master cpu
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT_ACK} tx_state_t;

   logic [7:0]    tx_mem [DEPTH];
   logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [AW:0]   tx_count;
   logic          tx_empty, tx_push, tx_pop;
   tx_state_t     tx_state;
   logic [7:0]    d0_q;
   logic          tx_flag;

   logic [7:0]    rx_mem [DEPTH];
   logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [AW:0]   rx_count, rx_count_next;
   logic          rx_full, rx_push, rx_pop;
   logic          rx_ack, rx_full_q;

   // TX FIFO: the FSM is the only consumer, popping in IDLE.
   assign tx_full  = (tx_count == CNT_FULL);
   assign tx_empty = (tx_count == '0);
   assign tx_push  = tx_wr && !tx_full;
   assign tx_pop   = (tx_state == TX_IDLE) && !tx_empty;
   assign busy     = (tx_state != TX_IDLE) || !tx_empty;

   always_ff @(posedge clk) begin
      if (tx_push)
         tx_mem[tx_wr_ptr] <= tx_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push)
            tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
         if (tx_pop)
            tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
         if (tx_push && !tx_pop)
            tx_count <= tx_count + CNT_ONE;
         else if (!tx_push && tx_pop)
            tx_count <= tx_count - CNT_ONE;
      end
   end

   // Data goes out in IDLE, the flag flips in LOAD, so d0_e leads the flag edge by a cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state <= TX_IDLE;
         d0_q     <= '0;
         tx_flag  <= 1'b0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (!tx_empty) begin
                  d0_q     <= tx_mem[tx_rd_ptr];
                  tx_state <= TX_LOAD;
               end
            end
            TX_LOAD: begin
               tx_flag  <= ~tx_flag;
               tx_state <= TX_WAIT_ACK;
            end
            TX_WAIT_ACK: begin
               if (cpu.d1_s[0] == tx_flag)
                  tx_state <= TX_IDLE;
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

`ifdef PUERTOS_HOST_ACK_TIMEOUT_EN
   localparam logic [7:0] TO_MAX  = 8'(TIMEOUT);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [7:0] to_cnt;
   logic       to_err;

   // Counter restarts while in LOAD, i.e. on every entry to WAIT_ACK; the error fires as it reaches TIMEOUT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt <= '0;
         to_err <= 1'b0;
      end else if (tx_state == TX_LOAD) begin
         to_cnt <= '0;
      end else if (tx_state == TX_WAIT_ACK && to_cnt != TO_MAX) begin
         to_cnt <= to_cnt + 8'd1;
         if (to_cnt == TO_LAST)
            to_err <= 1'b1;
      end
   end

   assign timeout_err = to_err;
`else
   assign timeout_err = 1'b0;
`endif

   // RX: capture and ack on the same edge, but only while there is room.
   assign rx_full  = (rx_count == CNT_FULL);
   assign rx_empty = (rx_count == '0);
   assign rx_push  = (cpu.d3_s[0] != rx_ack) && !rx_full;
   assign rx_pop   = rx_rd && !rx_empty;
   assign rx_data  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

   always_comb begin
      rx_count_next = rx_count;
      if (rx_push && !rx_pop)
         rx_count_next = rx_count + CNT_ONE;
      else if (!rx_push && rx_pop)
         rx_count_next = rx_count - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (rx_push)
         rx_mem[rx_wr_ptr] <= cpu.d2_s;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
         rx_ack    <= 1'b0;
         rx_full_q <= 1'b0;
      end else begin
         rx_count  <= rx_count_next;
         rx_full_q <= (rx_count_next == CNT_FULL);
         if (rx_push) begin
            rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            rx_ack    <= cpu.d3_s[0];
         end
         if (rx_pop)
            rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      end
   end

   assign cpu.d0_e = d0_q;
   assign cpu.d1_e = {7'b0, tx_flag};
   assign cpu.d2_e = {7'b0, rx_full_q};
   assign cpu.d3_e = {7'b0, rx_ack};

   logic unused_port_bits;
   assign unused_port_bits = ^{cpu.d0_s, cpu.d1_s[7:1], cpu.d3_s[7:1]};
endmodule
